// File: rtl/led_blink_pkg.sv
// ============================================================================
//  led_blink_pkg : shared mode encoding for the LED blink bank
//  Rev 1.0
// ============================================================================
`default_nettype none

package led_blink_pkg;

  typedef logic [1:0] mode_t;

  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_ON      = 2'd1;
  localparam logic [1:0] MODE_BLINK   = 2'd2;
  localparam logic [1:0] MODE_ONESHOT = 2'd3;

endpackage : led_blink_pkg

`default_nettype wire

// File: rtl/led_blink_chan.sv
// ============================================================================
//  led_blink_chan : one LED channel (mode, half-period counter, LED, toggle)
//  Optional macro: LED_BLINK_SYNC_EN adds the i_Sync phase-alignment input.
//  Rev 1.0
// ============================================================================
`default_nettype none

module led_blink_chan
  import led_blink_pkg::*;
#(
  parameter int CNT_W    = 25,
  parameter int DEF_HALF = 12500000
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Wr_En,
  input  logic [1:0]       i_Wr_Mode,
  input  logic [CNT_W-1:0] i_Wr_Half,
`ifdef LED_BLINK_SYNC_EN
  input  logic             i_Sync,
`endif
  output logic             o_LED,
  output logic             o_Toggle
);

  localparam logic [CNT_W-1:0] c_DEF_HALF = CNT_W'(DEF_HALF);
  localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);

  mode_t            r_mode;
  logic [CNT_W-1:0] r_half;
  logic [CNT_W-1:0] r_cnt;
  logic             r_led;
  logic             r_tog;

  logic             w_tc;
  logic [CNT_W-1:0] w_wr_half;

  assign w_tc      = (r_cnt == (r_half - c_ONE));
  // A zero half-period would never reach terminal count; clamp it to one.
  assign w_wr_half = (i_Wr_Half == '0) ? c_ONE : i_Wr_Half;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_mode <= MODE_BLINK;
      r_half <= c_DEF_HALF;
      r_cnt  <= '0;
      r_led  <= 1'b0;
      r_tog  <= 1'b0;
    end else if (i_Wr_En) begin
      r_mode <= i_Wr_Mode;
      r_half <= w_wr_half;
      r_cnt  <= '0;
      r_led  <= (i_Wr_Mode != MODE_OFF);
      r_tog  <= 1'b0;
`ifdef LED_BLINK_SYNC_EN
    end else if (i_Sync && (r_mode == MODE_BLINK)) begin
      r_cnt  <= '0;
      r_led  <= 1'b1;
      r_tog  <= 1'b0;
`endif
    end else begin
      r_tog <= 1'b0;
      case (r_mode)
        MODE_OFF: begin
          r_cnt <= '0;
          r_led <= 1'b0;
        end
        MODE_ON: begin
          r_cnt <= '0;
          r_led <= 1'b1;
        end
        MODE_BLINK: begin
          if (w_tc) begin
            r_cnt <= '0;
            r_led <= ~r_led;
            r_tog <= 1'b1;
          end else begin
            r_cnt <= r_cnt + c_ONE;
          end
        end
        MODE_ONESHOT: begin
          if (w_tc) begin
            r_cnt  <= '0;
            r_led  <= 1'b0;
            r_tog  <= 1'b1;
            r_mode <= MODE_OFF;
          end else begin
            r_cnt <= r_cnt + c_ONE;
          end
        end
      endcase
    end
  end

  assign o_LED    = r_led;
  assign o_Toggle = r_tog;

endmodule : led_blink_chan

`default_nettype wire

// File: rtl/led_blink_bank.sv
// ============================================================================
//  led_blink_bank : NUM_CH independent LED blink channels with write decode
//  Optional macro: LED_BLINK_SYNC_EN adds i_Sync to phase-align BLINK channels.
//  Rev 1.0
// ============================================================================
`default_nettype none

module led_blink_bank
  import led_blink_pkg::*;
#(
  parameter  int NUM_CH   = 4,
  parameter  int CNT_W    = 25,
  parameter  int DEF_HALF = 12500000,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_Wr_En,
  input  logic [CH_W-1:0]   i_Wr_Ch,
  input  logic [1:0]        i_Wr_Mode,
  input  logic [CNT_W-1:0]  i_Wr_Half,
`ifdef LED_BLINK_SYNC_EN
  input  logic              i_Sync,
`endif
  output logic [NUM_CH-1:0] o_LED,
  output logic [NUM_CH-1:0] o_Toggle
);

  // Out-of-range channel indices match no instance, so such writes vanish.
  logic [NUM_CH-1:0] w_wr_hit;

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    assign w_wr_hit[n] = i_Wr_En && (i_Wr_Ch == CH_W'(n));

    led_blink_chan #(
      .CNT_W    (CNT_W),
      .DEF_HALF (DEF_HALF)
    ) u_chan (
      .i_Clk     (i_Clk),
      .i_Rst     (i_Rst),
      .i_Wr_En   (w_wr_hit[n]),
      .i_Wr_Mode (i_Wr_Mode),
      .i_Wr_Half (i_Wr_Half),
`ifdef LED_BLINK_SYNC_EN
      .i_Sync    (i_Sync),
`endif
      .o_LED     (o_LED[n]),
      .o_Toggle  (o_Toggle[n])
    );
  end

endmodule : led_blink_bank

`default_nettype wire

// File: tb/tb_led_blink_bank.sv
// ============================================================================
//  tb_led_blink_bank : randomized scoreboard bench for led_blink_bank
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_led_blink_bank;

  localparam int NCH = 4;
  localparam int CW  = 8;
  localparam int DH  = 3;

  localparam int M_OFF = 0, M_ON = 1, M_BLINK = 2, M_ONESHOT = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [1:0]    wr_ch = '0;
  logic [1:0]    wr_mode = '0;
  logic [CW-1:0] wr_half = '0;
  logic          sync = 1'b0;
  logic [NCH-1:0] led, tog;
  logic [2:0]     led3, tog3;

  always #5 clk = ~clk;

  led_blink_bank #(.NUM_CH(NCH), .CNT_W(CW), .DEF_HALF(DH)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Wr_En(wr_en), .i_Wr_Ch(wr_ch),
    .i_Wr_Mode(wr_mode), .i_Wr_Half(wr_half),
`ifdef LED_BLINK_SYNC_EN
    .i_Sync(sync),
`endif
    .o_LED(led), .o_Toggle(tog)
  );

  // Three-channel copy: writes to index 3 must be ignored there.
  led_blink_bank #(.NUM_CH(3), .CNT_W(CW), .DEF_HALF(DH)) dut3 (
    .i_Clk(clk), .i_Rst(rst), .i_Wr_En(wr_en), .i_Wr_Ch(wr_ch),
    .i_Wr_Mode(wr_mode), .i_Wr_Half(wr_half),
`ifdef LED_BLINK_SYNC_EN
    .i_Sync(sync),
`endif
    .o_LED(led3), .o_Toggle(tog3)
  );

  typedef struct packed {
    logic [NCH-1:0] led;
    logic [NCH-1:0] tog;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Model: each channel remembers when it last restarted and its LED then;
  // outputs follow from elapsed time by division, not a cycle counter.
  int m_mode[NCH], m_half[NCH], m_t[NCH], m_start[NCH];

  function automatic exp_t model_out();
    exp_t e;
    e = '0;
    for (int c = 0; c < NCH; c++) begin
      case (m_mode[c])
        M_ON: e.led[c] = 1'b1;
        M_BLINK: begin
          e.led[c] = 1'(m_start[c] ^ ((m_t[c] / m_half[c]) % 2));
          e.tog[c] = (m_t[c] > 0) && (m_t[c] % m_half[c] == 0);
        end
        M_ONESHOT: begin
          e.led[c] = (m_t[c] < m_half[c]);
          e.tog[c] = (m_t[c] == m_half[c]);
        end
        default: ;
      endcase
    end
    return e;
  endfunction

  task automatic model_step();
    for (int c = 0; c < NCH; c++) begin
      if (rst) begin
        m_mode[c] = M_BLINK; m_half[c] = DH; m_t[c] = 0; m_start[c] = 0;
      end else if (wr_en && (int'(wr_ch) == c)) begin
        m_mode[c]  = int'(wr_mode);
        m_half[c]  = (wr_half == 0) ? 1 : int'(wr_half);
        m_t[c]     = 0;
        m_start[c] = (wr_mode != 2'd0) ? 1 : 0;
      end else if (sync && m_mode[c] == M_BLINK) begin
        m_t[c] = 0; m_start[c] = 1;
      end else begin
        m_t[c]++;
      end
    end
  endtask

  // One clock: update the model from the inputs held across the edge,
  // queue the expectation, then release inputs 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    model_step();
    exp_q.push_back(model_out());
    #1;
  endtask

  task automatic do_write(input int ch, input int mode, input int half);
    wr_en = 1'b1; wr_ch = 2'(ch); wr_mode = 2'(mode); wr_half = CW'(half);
    cyc();
    wr_en = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (led !== e.led) begin
          errors++;
          $display("FAIL led: got %b expected %b at %0t", led, e.led, $time);
        end
        checks++;
        if (tog !== e.tog) begin
          errors++;
          $display("FAIL toggle: got %b expected %b at %0t", tog, e.tog, $time);
        end
        checks++;
        if (led3 !== e.led[2:0] || tog3 !== e.tog[2:0]) begin
          errors++;
          $display("FAIL nch3: got led %b tog %b expected led %b tog %b at %0t",
                   led3, tog3, e.led[2:0], e.tog[2:0], $time);
        end
      end
    end
  end

  initial begin : stim
    int n;
    #1;
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    repeat (10) cyc();

    do_write(2, M_BLINK, 0);
    repeat (6) cyc();

    do_write(1, M_ONESHOT, 5);
    repeat (10) cyc();

    // Land a ch3 write exactly on its terminal-count edge.
    do_write(3, M_BLINK, 3);
    n = 0;
    while (!(((m_t[3] + 1) % m_half[3]) == 0) && n < 10) begin
      cyc();
      n++;
    end
    do_write(3, M_BLINK, 3);
    repeat (8) cyc();

    do_write(0, M_ONESHOT, 5);
    cyc(); cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    repeat (8) cyc();

    // Index 3 writes exercise the ignored path on the three-channel copy.
    do_write(3, M_ON, 2);
    repeat (4) cyc();

    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 199) == 0);
      wr_en   = ($urandom_range(0, 7) == 0);
      wr_ch   = 2'($urandom_range(0, 3));
      wr_mode = 2'($urandom_range(0, 3));
      wr_half = CW'($urandom_range(0, 6));
`ifdef LED_BLINK_SYNC_EN
      sync    = ($urandom_range(0, 31) == 0);
`endif
      cyc();
    end
    rst = 1'b0; wr_en = 1'b0; sync = 1'b0;

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_led_blink_bank

`default_nettype wire

// File: doc/led_blink_bank.md
LED_BLINK_BANK -- requirements
Module: led_blink_bank

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent LED channels (1..16).
REQ-002 Parameter CNT_W, default 25: width of each channel's half-period counter and register.
REQ-003 Parameter DEF_HALF, default 12500000: half-period loaded into every channel at reset (1 Hz at 25 MHz); must fit in CNT_W.
REQ-004 Derived CH_W = max(1, clog2(NUM_CH)).
REQ-005 i_Clk  input  1  sole clock; all state on its rising edge.
REQ-006 i_Rst  input  1  reset, synchronous, active-high.
REQ-007 i_Wr_En  input  1  single-cycle channel configuration write strobe.
REQ-008 i_Wr_Ch  input  CH_W  target channel index for the write.
REQ-009 i_Wr_Mode  input  2  mode: 0 OFF, 1 ON, 2 BLINK, 3 ONESHOT.
REQ-010 i_Wr_Half  input  CNT_W  half-period in clock cycles.
REQ-011 o_LED  output  NUM_CH  registered LED drive, bit n = channel n.
REQ-012 o_Toggle  output  NUM_CH  registered one-cycle pulse, high in the same cycle o_LED[n] changes due to a terminal count.

Function
REQ-013 Each channel holds mode, half-period (effective half = max(i_Wr_Half, 1)), counter and LED state.
REQ-014 OFF: LED 0, counter held 0. ON: LED 1, counter held 0. No o_Toggle pulses in either mode.
REQ-015 BLINK: counter increments each cycle. At counter == half-1: counter wraps to 0, LED inverts, o_Toggle pulses. Full period = 2*half cycles.
REQ-016 ONESHOT: LED 1 and counting. At first terminal count: LED to 0, o_Toggle pulses, mode becomes OFF.
REQ-017 A write with i_Wr_En=1 and i_Wr_Ch<NUM_CH loads mode and half into that channel and sets its counter to 0. LED becomes 0 for OFF, 1 for ON/BLINK/ONESHOT. All changes are visible on o_LED the next cycle (1-cycle latency).
REQ-018 A write with i_Wr_Ch>=NUM_CH is ignored entirely.
REQ-019 A write in the same cycle as that channel's terminal count wins: no o_Toggle pulse, and the channel restarts per REQ-017.
REQ-020 Channels not written are unaffected by a write and keep counting without disturbance.
REQ-021 Counter never exceeds half-1. Changing half is only possible by write, so no overrun case exists.

Reset
REQ-022 With i_Rst=1 at a clock edge, every channel goes to mode BLINK, half=DEF_HALF, counter 0, o_LED 0, o_Toggle 0.
REQ-023 Reset has priority over writes and sync. Reset mid-ONESHOT or mid-period discards that state.
REQ-024 After release, the first LED rise occurs DEF_HALF cycles after the first non-reset edge.

Configuration
REQ-025 Macro LED_BLINK_SYNC_EN defined: adds input i_Sync (1 bit). When i_Sync=1 and i_Rst=0, every channel in BLINK mode sets counter 0 and LED 1 that edge with no o_Toggle. A simultaneous write to a channel takes precedence for that channel only.
REQ-026 Macro undefined: i_Sync is absent and channels have no phase-alignment path. All other behaviour is identical.

Structure
REQ-027 Shared package led_blink_pkg holds the 2-bit mode type with constants MODE_OFF, MODE_ON, MODE_BLINK, MODE_ONESHOT.
REQ-028 Sub-module led_blink_chan implements one channel: mode, counter, LED, toggle. led_blink_bank instantiates NUM_CH copies and decodes write/sync per channel.

Verification (NUM_CH=4, CNT_W=8, DEF_HALF=3)
REQ-029 Reset 2 cycles, then release: all o_LED rise on the 3rd edge and toggle every 3 cycles; o_Toggle pulses on each change.
REQ-030 Write ch2 BLINK half=0: o_LED[2] inverts every cycle and o_Toggle[2] stays 1; other channels keep their 3-cycle cadence.
REQ-031 Write ch1 ONESHOT half=5: o_LED[1]=1 for exactly 5 cycles, then 0 with a single o_Toggle[1] pulse, and stays 0 thereafter.
REQ-032 Write ch3 BLINK half=3 on ch3's terminal-count cycle: no o_Toggle[3], o_LED[3]=1 next cycle, next toggle 3 cycles later. With NUM_CH=3, a write to ch=3 changes nothing.
REQ-033 Assert i_Rst mid-ONESHOT on ch0: ch0 returns to BLINK half=3 with LED 0 and resumes per REQ-029.
REQ-034 With LED_BLINK_SYNC_EN, channels at half=3,4,5 with i_Sync pulsed once: all three o_LED read 1 the next cycle and first toggle after 3, 4 and 5 cycles respectively.
